// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
// Holds the FSM encoding, data width and parity helpers.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic parity_bit(
        input logic [DATA_WIDTH-1:0] data,
        input logic                  typ
    );
        return (^data) ^ (typ == PAR_ODD);
    endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// Oversample edge counter and bit counter for the UART receiver.
// edge_count wraps at prescale-1; each wrap is one bit end.
module edge_bit_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [5:0] prescale,
    input  logic       clear,
    output logic [5:0] edge_count,
    output logic [3:0] bit_count,
    output logic       bit_end
);

    assign bit_end = enable && (edge_count == prescale - 6'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (clear) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (enable) begin
            if (bit_end) begin
                edge_count <= '0;
                bit_count  <= bit_count + 4'd1;
            end else begin
                edge_count <= edge_count + 6'd1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, deserializer and
// parity/stop checks driving a shared data sampler.
import uart_rx_pkg::*;

module uart_rx_ctrl (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  dat_samp_en,
    output logic [5:0]            edge_count,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    state_t                state;
    logic [5:0]            pre_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_flag;
    logic [3:0]            bit_count;
    logic                  bit_end;
    logic                  cnt_en;
    logic                  cnt_clr;

    assign cnt_en = (state != IDLE);

    // Restart bit numbering so DATA sees bit_count 0..7.
    assign cnt_clr = (state == IDLE)
                   || (state == START && bit_end);

    edge_bit_counter u_cnt (
        .clk        (CLK),
        .rst_n      (RST),
        .enable     (cnt_en),
        .prescale   (pre_q),
        .clear      (cnt_clr),
        .edge_count (edge_count),
        .bit_count  (bit_count),
        .bit_end    (bit_end)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            pre_q       <= 6'd8;
            par_en_q    <= 1'b0;
            par_typ_q   <= PAR_EVEN;
            shreg       <= '0;
            par_flag    <= 1'b0;
            P_DATA      <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            dat_samp_en <= 1'b0;
            busy        <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!RX_IN) begin
                        state       <= START;
                        pre_q       <= Prescale;
                        par_en_q    <= PAR_EN;
                        par_typ_q   <= PAR_TYP;
                        par_flag    <= 1'b0;
                        dat_samp_en <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        if (sampled_bit) begin
                            state       <= IDLE;
                            dat_samp_en <= 1'b0;
                            busy        <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shreg <= {sampled_bit,
                                  shreg[DATA_WIDTH-1:1]};
                        if (bit_count == 4'(DATA_WIDTH - 1))
                            state <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        par_flag <= sampled_bit !=
                                    parity_bit(shreg, par_typ_q);
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state       <= IDLE;
                        dat_samp_en <= 1'b0;
                        busy        <= 1'b0;
                        stp_err     <= !sampled_bit;
                        par_err     <= par_flag;
                        if (sampled_bit && !par_flag) begin
                            P_DATA     <= shreg;
                            data_valid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
